// File: rtl/priority_grant_scheduler.sv
// Priority grant scheduler: 8 requesters, 2-bit stored priority, age promotion
// to top priority after AGE_LIMIT lost handshakes, round-robin tie-break, and a
// registered valid/ready grant that is held until accepted.
module priority_grant_scheduler #(
    parameter int unsigned AGE_LIMIT = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [1:0] priorityIn0,
    input  logic [1:0] priorityIn1,
    input  logic [1:0] priorityIn2,
    input  logic [1:0] priorityIn3,
    input  logic [1:0] priorityIn4,
    input  logic [1:0] priorityIn5,
    input  logic [1:0] priorityIn6,
    input  logic [1:0] priorityIn7,
    input  logic       grant_ready,
    output logic       grant_valid,
    output logic [2:0] grant_id,
    output logic [7:0] grant_onehot,
    output logic [1:0] grant_priority,
    output logic       grant_aged
);

    localparam int unsigned N   = 8;
    localparam int unsigned IDW = 3;
    localparam int unsigned PW  = 2;
    localparam int unsigned AW  = 4;
    localparam logic [AW-1:0] AGE_MAX = '1;
    localparam logic [AW-1:0] AGE_LIM = AW'(AGE_LIMIT);
    localparam logic [PW-1:0] PRI_TOP = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] id_q, id_d;
    logic [N-1:0]   onehot_q, onehot_d;
    logic [PW-1:0]  pri_q, pri_d;
    logic           aged_q, aged_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [AW-1:0]  age_q [N];
    logic [AW-1:0]  age_d [N];

    logic [PW-1:0]  pri_in   [N];
    logic [PW-1:0]  eff_pri  [N];
    logic [N-1:0]   is_aged;
    logic [IDW-1:0] scan_idx;
    logic [IDW-1:0] win_id;
    logic [PW-1:0]  win_pri;
    logic           win_found;
    logic           handshake;

    assign pri_in[0] = priorityIn0;
    assign pri_in[1] = priorityIn1;
    assign pri_in[2] = priorityIn2;
    assign pri_in[3] = priorityIn3;
    assign pri_in[4] = priorityIn4;
    assign pri_in[5] = priorityIn5;
    assign pri_in[6] = priorityIn6;
    assign pri_in[7] = priorityIn7;

    assign handshake = (state_q == GRANT) && grant_ready;

    // Effective priority: aged entries are promoted to the top level
    always_comb begin
        for (int i = 0; i < N; i++) begin
            is_aged[i] = (age_q[i] >= AGE_LIM);
            eff_pri[i] = is_aged[i] ? PRI_TOP : pri_in[i];
        end
    end

    // Winner search in round-robin order; strict '>' keeps the first-found entry on ties
    always_comb begin
        win_id    = rr_q;
        win_pri   = '0;
        win_found = 1'b0;
        scan_idx  = rr_q;
        for (int k = 0; k < N; k++) begin
            scan_idx = rr_q + IDW'(k);
            if (req[scan_idx] && (!win_found || (eff_pri[scan_idx] > win_pri))) begin
                win_found = 1'b1;
                win_id    = scan_idx;
                win_pri   = eff_pri[scan_idx];
            end
        end
    end

    // Next-state, grant payload, round-robin pointer and age counters
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        id_d     = id_q;
        onehot_d = onehot_q;
        pri_d    = pri_q;
        aged_d   = aged_q;
        rr_d     = rr_q;
        for (int i = 0; i < N; i++) begin
            age_d[i] = age_q[i];
        end

        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d  = GRANT;
                    valid_d  = 1'b1;
                    id_d     = win_id;
                    onehot_d = N'(1) << win_id;
                    pri_d    = win_pri;
                    aged_d   = is_aged[win_id] && (pri_in[win_id] != PRI_TOP);
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    id_d     = '0;
                    onehot_d = '0;
                    pri_d    = '0;
                    aged_d   = 1'b0;
                    rr_d     = id_q + IDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < N; i++) begin
            if (!req[i]) begin
                age_d[i] = '0;
            end else if (handshake) begin
                if (IDW'(i) == id_q) begin
                    age_d[i] = '0;
                end else if (age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + AW'(1);
                end
            end
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            id_q     <= '0;
            onehot_q <= '0;
            pri_q    <= '0;
            aged_q   <= 1'b0;
            rr_q     <= '0;
            for (int i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            onehot_q <= onehot_d;
            pri_q    <= pri_d;
            aged_q   <= aged_d;
            rr_q     <= rr_d;
            for (int i = 0; i < N; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign grant_valid    = valid_q;
    assign grant_id       = id_q;
    assign grant_onehot   = onehot_q;
    assign grant_priority = pri_q;
    assign grant_aged     = aged_q;

endmodule

// File: tb/tb_priority_grant_scheduler.sv
// Bench for priority_grant_scheduler: vector table plus multi-cycle sequences,
// with a grant scoreboard popped on every observed handshake.
module tb_priority_grant_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [1:0] pri [8];
    logic       ready;

    logic       v7, v2, v4;
    logic [2:0] id7, id2, id4;
    logic [7:0] oh7, oh2, oh4;
    logic [1:0] p7, p2, p4;
    logic       a7, a2, a4;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned sel = 0;

    logic       m_valid;
    logic [2:0] m_id;
    logic [7:0] m_onehot;
    logic [1:0] m_pri;
    logic       m_aged;

    typedef struct packed {
        logic [2:0] id;
        logic [1:0] pri;
        logic       aged;
    } exp_t;
    exp_t sb_q [$];

    typedef struct {
        logic [7:0]  req;
        logic [15:0] pri;
        logic        exp_valid;
        logic [2:0]  exp_id;
        logic [1:0]  exp_pri;
        logic        exp_aged;
    } vec_t;
    vec_t vecs [7];

    priority_grant_scheduler #(.AGE_LIMIT(7)) u_dut7 (
        .clk(clk), .reset(rst_n), .req(req),
        .priorityIn0(pri[0]), .priorityIn1(pri[1]), .priorityIn2(pri[2]), .priorityIn3(pri[3]),
        .priorityIn4(pri[4]), .priorityIn5(pri[5]), .priorityIn6(pri[6]), .priorityIn7(pri[7]),
        .grant_ready(ready), .grant_valid(v7), .grant_id(id7), .grant_onehot(oh7),
        .grant_priority(p7), .grant_aged(a7)
    );

    priority_grant_scheduler #(.AGE_LIMIT(2)) u_dut2 (
        .clk(clk), .reset(rst_n), .req(req),
        .priorityIn0(pri[0]), .priorityIn1(pri[1]), .priorityIn2(pri[2]), .priorityIn3(pri[3]),
        .priorityIn4(pri[4]), .priorityIn5(pri[5]), .priorityIn6(pri[6]), .priorityIn7(pri[7]),
        .grant_ready(ready), .grant_valid(v2), .grant_id(id2), .grant_onehot(oh2),
        .grant_priority(p2), .grant_aged(a2)
    );

    priority_grant_scheduler #(.AGE_LIMIT(4)) u_dut4 (
        .clk(clk), .reset(rst_n), .req(req),
        .priorityIn0(pri[0]), .priorityIn1(pri[1]), .priorityIn2(pri[2]), .priorityIn3(pri[3]),
        .priorityIn4(pri[4]), .priorityIn5(pri[5]), .priorityIn6(pri[6]), .priorityIn7(pri[7]),
        .grant_ready(ready), .grant_valid(v4), .grant_id(id4), .grant_onehot(oh4),
        .grant_priority(p4), .grant_aged(a4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Select which instance the checks observe
    always_comb begin
        case (sel)
            1: begin m_valid = v2; m_id = id2; m_onehot = oh2; m_pri = p2; m_aged = a2; end
            2: begin m_valid = v4; m_id = id4; m_onehot = oh4; m_pri = p4; m_aged = a4; end
            default: begin m_valid = v7; m_id = id7; m_onehot = oh7; m_pri = p7; m_aged = a7; end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pri();
        for (int i = 0; i < 8; i++) pri[i] = 2'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        clear_pri();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Arbitration happens on the next edge; accept the grant and confirm the gap cycle
    task automatic grant_once(input logic [2:0] id, input logic [1:0] p, input logic a);
        tick();
        sb_q.push_back({id, p, a});
        ready = 1'b1;
        @(negedge clk);
        chk("grant_valid_up", 32'(m_valid), 1);
        tick();
        ready = 1'b0;
        req   = '0;
        @(negedge clk);
        chk("grant_valid_gap", 32'(m_valid), 0);
        chk("grant_onehot_gap", 32'(m_onehot), 0);
    endtask

    // Scoreboard: every accepted grant must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && m_valid && ready) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected_grant: got id %0d with nothing expected at %0t", m_id, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_grant_id", 32'(m_id), 32'(e.id));
                chk("sb_grant_onehot", 32'(m_onehot), 32'(8'd1 << e.id));
                chk("sb_grant_priority", 32'(m_pri), 32'(e.pri));
                chk("sb_grant_aged", 32'(m_aged), 32'(e.aged));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h24, 16'h0C10, 1'b1, 3'd5, 2'd3, 1'b0};
        vecs[1] = '{8'h81, 16'h5555, 1'b1, 3'd0, 2'd1, 1'b0};
        vecs[2] = '{8'h0A, 16'h0088, 1'b1, 3'd1, 2'd2, 1'b0};
        vecs[3] = '{8'hF0, 16'h5403, 1'b1, 3'd5, 2'd1, 1'b0};
        vecs[4] = '{8'h80, 16'h3FFF, 1'b1, 3'd7, 2'd0, 1'b0};
        vecs[5] = '{8'h00, 16'hFFFF, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[6] = '{8'h42, 16'h200C, 1'b1, 3'd1, 2'd3, 1'b0};

        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        clear_pri();
        sel = 0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_id", 32'(m_id), 0);
        chk("rst_onehot", 32'(m_onehot), 0);
        chk("rst_priority", 32'(m_pri), 0);
        chk("rst_aged", 32'(m_aged), 0);

        // Single-shot arbitration vectors, each from a fresh reset
        for (int v = 0; v < 7; v++) begin
            do_reset();
            req = vecs[v].req;
            for (int i = 0; i < 8; i++) pri[i] = vecs[v].pri[2*i +: 2];
            if (vecs[v].exp_valid) begin
                grant_once(vecs[v].exp_id, vecs[v].exp_pri, vecs[v].exp_aged);
            end else begin
                repeat (2) begin
                    tick();
                    @(negedge clk);
                    chk("vec_no_grant", 32'(m_valid), 0);
                end
            end
        end

        // Round robin across all eight equal-priority requesters; the last two win by age
        sel = 0;
        do_reset();
        for (int g = 0; g < 7; g++) sb_q.push_back({3'(g), 2'd2, 1'b0});
        sb_q.push_back({3'd7, 2'd3, 1'b1});
        sb_q.push_back({3'd0, 2'd3, 1'b1});
        req = 8'hFF;
        for (int i = 0; i < 8; i++) pri[i] = 2'd2;
        ready = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            @(negedge clk);
            chk("rr_valid_phase", 32'(m_valid), 32'(k % 2));
        end
        req   = '0;
        ready = 1'b0;
        tick();

        // Age promotion with AGE_LIMIT=2
        sel = 1;
        do_reset();
        sb_q.push_back({3'd0, 2'd3, 1'b0});
        sb_q.push_back({3'd0, 2'd3, 1'b0});
        sb_q.push_back({3'd1, 2'd3, 1'b1});
        req    = 8'h03;
        pri[0] = 2'd3;
        pri[1] = 2'd0;
        ready  = 1'b1;
        repeat (6) tick();
        req   = '0;
        ready = 1'b0;
        @(negedge clk);
        chk("age2_drained", sb_q.size(), 0);

        // Grant held stable while inputs churn and ready stays low
        sel = 0;
        do_reset();
        req    = 8'h12;
        pri[1] = 2'd1;
        pri[4] = 2'd2;
        tick();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_id", 32'(m_id), 4);
            chk("hold_onehot", 32'(m_onehot), 32'h10);
            chk("hold_priority", 32'(m_pri), 2);
            chk("hold_aged", 32'(m_aged), 0);
            req = 8'($urandom);
            for (int i = 0; i < 8; i++) pri[i] = 2'($urandom);
            tick();
        end
        req = 8'h12;
        clear_pri();
        pri[1] = 2'd1;
        pri[4] = 2'd2;
        sb_q.push_back({3'd4, 2'd2, 1'b0});
        ready = 1'b1;
        tick();
        ready = 1'b0;
        req   = 8'h30;
        clear_pri();
        pri[4] = 2'd1;
        pri[5] = 2'd1;
        grant_once(3'd5, 2'd1, 1'b0);

        // Asynchronous reset during a pending grant discards it
        sel = 0;
        do_reset();
        req    = 8'h08;
        pri[3] = 2'd2;
        tick();
        @(negedge clk);
        chk("pre_reset_valid", 32'(m_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(m_valid), 0);
        chk("async_reset_id", 32'(m_id), 0);
        chk("async_reset_onehot", 32'(m_onehot), 0);
        req = '0;
        clear_pri();
        tick();
        tick();
        rst_n  = 1'b1;
        req    = 8'h11;
        pri[0] = 2'd1;
        pri[4] = 2'd1;
        grant_once(3'd0, 2'd1, 1'b0);

        // Dropping a request clears its age, so no aged win follows (AGE_LIMIT=4)
        sel = 2;
        do_reset();
        for (int g = 0; g < 6; g++) sb_q.push_back({3'd0, 2'd3, 1'b0});
        sb_q.push_back({3'd3, 2'd0, 1'b0});
        req    = 8'h09;
        pri[0] = 2'd3;
        pri[3] = 2'd0;
        ready  = 1'b1;
        repeat (8) tick();
        req = 8'h01;
        tick();
        req = 8'h09;
        repeat (3) tick();
        req = 8'h08;
        repeat (2) tick();
        req   = '0;
        ready = 1'b0;
        tick();
        @(negedge clk);
        chk("age_clear_idle", 32'(m_valid), 0);

        chk("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
